// File: rtl/tl_sched_if.sv
// Sensor, pedestrian and lamp signals between the intersection and tl_sched.
// The slave side is the scheduler. The master side is whatever drives the sensors and reads the lamps.
interface tl_sched_if;
    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       walk;
    logic       ped_pend;

    modport master (
        output Ta, Tb, ped_req,
        input  La, Lb, walk, ped_pend
    );

    modport slave (
        input  Ta, Tb, ped_req,
        output La, Lb, walk, ped_pend
    );
endinterface

// File: rtl/tl_sched.sv
// Two-road traffic-light phase scheduler with a latched pedestrian all-red walk phase.
// Lamps are a pure Moore decode of the phase register.
module tl_sched #(
    parameter int T_MIN_GREEN = 4,
    parameter int T_MAX_GREEN = 8,
    parameter int T_YELLOW    = 2,
    parameter int T_WALK      = 3,
    parameter int TW          = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    tl_sched_if.slave    bus
);
    typedef enum logic [2:0] {S_AG, S_AY, S_BG, S_BY, S_WALK} state_t;

    localparam logic [TW-1:0] C_MIN  = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] C_MAX  = TW'(T_MAX_GREEN - 1);
    localparam logic [TW-1:0] C_YEL  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] C_WALK = TW'(T_WALK - 1);

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tmr, w_tmr_next, w_tmr_exit;
    logic          r_pend, w_pend_next;
    logic          r_nxt_b, w_nxt_b_next;
    logic          w_pend_eff;

    // A request arriving in the last yellow cycle still diverts that exit to WALK.
    assign w_pend_eff = r_pend | bus.ped_req;

    always_comb begin
        w_state_next = r_state;
        w_nxt_b_next = r_nxt_b;
        w_tmr_exit   = '0;
        case (r_state)
            S_AG: begin
                w_tmr_exit = C_MAX;
                if (r_tmr >= C_MIN && (bus.Tb || r_pend) && (!bus.Ta || r_tmr == C_MAX))
                    w_state_next = S_AY;
            end
            S_AY: begin
                w_tmr_exit = C_YEL;
                if (r_tmr == C_YEL) begin
                    if (w_pend_eff) begin
                        w_state_next = S_WALK;
                        w_nxt_b_next = 1'b1;
                    end else begin
                        w_state_next = S_BG;
                    end
                end
            end
            S_BG: begin
                w_tmr_exit = C_MAX;
                if (r_tmr >= C_MIN && (bus.Ta || r_pend) && (!bus.Tb || r_tmr == C_MAX))
                    w_state_next = S_BY;
            end
            S_BY: begin
                w_tmr_exit = C_YEL;
                if (r_tmr == C_YEL) begin
                    if (w_pend_eff) begin
                        w_state_next = S_WALK;
                        w_nxt_b_next = 1'b0;
                    end else begin
                        w_state_next = S_AG;
                    end
                end
            end
            S_WALK: begin
                w_tmr_exit = C_WALK;
                if (r_tmr == C_WALK)
                    w_state_next = r_nxt_b ? S_BG : S_AG;
            end
            default: begin
                w_state_next = S_AG;
            end
        endcase
    end

    // Timer restarts on every phase change and otherwise saturates at the phase exit value.
    always_comb begin
        w_tmr_next = r_tmr;
        if (w_state_next != r_state)
            w_tmr_next = '0;
        else if (r_tmr < w_tmr_exit)
            w_tmr_next = r_tmr + 1'b1;
    end

    always_comb begin
        w_pend_next = r_pend;
        if (r_state != S_WALK && w_state_next == S_WALK)
            w_pend_next = 1'b0;
        else if (r_state != S_WALK && bus.ped_req)
            w_pend_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_AG;
            r_tmr   <= '0;
            r_pend  <= 1'b0;
            r_nxt_b <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tmr   <= w_tmr_next;
            r_pend  <= w_pend_next;
            r_nxt_b <= w_nxt_b_next;
        end
    end

    always_comb begin
        bus.La   = 2'b10;
        bus.Lb   = 2'b10;
        bus.walk = 1'b0;
        case (r_state)
            S_AG:    bus.La   = 2'b00;
            S_AY:    bus.La   = 2'b01;
            S_BG:    bus.Lb   = 2'b00;
            S_BY:    bus.Lb   = 2'b01;
            S_WALK:  bus.walk = 1'b1;
            default: bus.La   = 2'b00;
        endcase
        bus.ped_pend = r_pend;
    end
endmodule

// File: doc/tl_sched.md
# tl_sched

Timed traffic-light phase scheduler for a two-road intersection (roads A and B) with a latched pedestrian request. It replaces free-running sensor-only sequencing with enforced minimum green, maximum green under contention, fixed yellow, and an all-red walk phase. It sits between the road sensors and pedestrian button inputs and the lamp drivers, and owns all phase sequencing for the intersection.

## Interface
- T_MIN_GREEN, 4: minimum green duration in cycles (≥1)
- T_MAX_GREEN, 8: green duration cap in cycles when the other side has demand (≥T_MIN_GREEN)
- T_YELLOW, 2: yellow duration in cycles (≥1)
- T_WALK, 3: pedestrian all-red walk duration in cycles (≥1)
- TW, 5: timer width; every duration parameter must be ≤ 2^TW−1

- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- Ta  input  1  vehicle present on road A (level, synchronous to clk)
- Tb  input  1  vehicle present on road B (level)
- ped_req  input  1  pedestrian request (level or pulse, sampled every cycle)
- La  output  2  road A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red
- Lb  output  2  road B lamp, same encoding as La
- walk  output  1  pedestrian walk lamp, high only in WALK
- ped_pend  output  1  pedestrian request latched, not yet served

## Operation
- States: AG (La=00, Lb=10), AY (La=01, Lb=10), BG (La=10, Lb=00), BY (La=10, Lb=01), WALK (La=10, Lb=10, walk=1).
- Moore machine: La, Lb, and walk decode from the state register only.
- Phase timer `tmr` (TW bits): cleared to 0 on every state change. Otherwise it increments each cycle and saturates at its exit value.
- Pedestrian latch `pend`:
  - set when ped_req=1 in any state except WALK
  - ped_req is ignored during WALK
  - cleared on the edge that enters WALK
  - ped_pend = pend
- Side register `nxt_b`: records which green follows WALK.
- AG exits to AY when tmr ≥ T_MIN_GREEN−1 AND (Tb | pend) AND (!Ta | tmr == T_MAX_GREEN−1).
  - With no demand from B or pedestrian, AG holds indefinitely and tmr saturates at T_MAX_GREEN−1.
- BG is symmetric: exits to BY when tmr ≥ T_MIN_GREEN−1 AND (Ta | pend) AND (!Tb | tmr == T_MAX_GREEN−1).
- AY exits when tmr == T_YELLOW−1:
  - to WALK with nxt_b←1 if pend
  - otherwise to BG
- BY exits when tmr == T_YELLOW−1:
  - to WALK with nxt_b←0 if pend
  - otherwise to AG
- WALK exits when tmr == T_WALK−1, to BG if nxt_b, else to AG.
- Simultaneous events:
  - ped_req arriving in the same cycle the AY/BY exit condition is evaluated is latched that cycle and diverts that exit to WALK.
  - ped_req in the final WALK cycle is dropped.
- Reset values (asserted at any time, takes effect immediately): state=AG, tmr=0, pend=0, nxt_b=1. Outputs: La=00, Lb=10, walk=0, ped_pend=0.

## Timing
- All state, tmr, pend, and nxt_b updates occur on the rising clk edge.
- Outputs change only after an edge, except on async reset assertion, where they change immediately.
- Phase durations in cycles:
  - green: T_MIN_GREEN minimum, T_MAX_GREEN maximum under contention, unbounded without demand
  - yellow: exactly T_YELLOW
  - walk: exactly T_WALK
- Sensor latency: a demand input seen high at edge n, with the timer condition met, gives yellow visible after edge n.
- ped_pend rises the cycle after the first sampled ped_req=1, and falls when walk rises.
- Release of reset_n is treated as synchronous to clk. The first timer count is taken at the first edge with reset_n=1.
- Walk is never adjacent to any green or yellow lamp: La=Lb=10 whenever walk=1.

## Test plan
1. Reset, then Ta=1, Tb=0, ped_req=0 for 30 cycles -> La=00, Lb=10 throughout; ped_pend=0.
2. Reset release with Ta=0, Tb=1 held -> AG for 4 cycles, AY for 2, then BG. BG holds as long as Ta=0 (La=10, Lb=00).
3. Ta=Tb=1 held -> repeating period of 20 cycles: AG 8, AY 2, BG 8, BY 2. Never both lamps non-red.
4. Ta=Tb=0; 1-cycle ped_req in the 2nd cycle after reset release:
   - ped_pend=1 from the next cycle
   - AG lasts 4 cycles, then AY 2
   - WALK 3 cycles (walk=1, La=Lb=10, ped_pend=0)
   - then BG
5. ped_req held high through an entire WALK, then released in the first cycle of BG -> exactly one walk. ped_pend is set again by the BG-cycle sample; with Ta=Tb=0, BG lasts 4 cycles, then BY 2, WALK 3, AG.
6. Assert reset_n=0 mid-BY (Tb=1) -> La=00, Lb=10, walk=0, ped_pend=0 before the next clk edge. After release, AG holds a full minimum of 4 cycles.
